// File: rtl/ifetch_frontend.sv
// ifetch_frontend: instruction-fetch front end.
//   Direct-mapped read-only instruction cache (64-byte lines, 8 x 64-bit beats)
//   refilled over the Sysbus, a static next-PC predictor and an RV64I field decoder.
// Ports:
//   clk, reset (synchronous, active-high)
//   fetch_req, pc                  : fetch request from the PC stage
//   busy                           : miss / refill in progress
//   instr_valid, instr, next_pc    : registered fetch result (one-cycle pulse per hit)
//   rs1, rs2, rd, imm, ctrl_bits   : decode of instr
//   bus_reqcyc/bus_req/bus_reqtag/bus_reqack       : line read request
//   bus_respcyc/bus_respack/bus_resp/bus_resptag   : refill beats
// Build option: IFETCH_BTFN_EN -- backward-taken/forward-not-taken prediction of
//   conditional branches; undefined means every conditional branch is not taken.
module ifetch_frontend #(
    parameter int NUM_LINES      = 64,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_req,
    input  logic [63:0]               pc,
    output logic                      busy,
    output logic                      instr_valid,
    output logic [31:0]               instr,
    output logic [63:0]               next_pc,
    output logic [4:0]                rs1,
    output logic [4:0]                rs2,
    output logic [4:0]                rd,
    output logic [63:0]               imm,
    output logic [15:0]               ctrl_bits,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 58 - IDX_W;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2} state_t;

    // Sign-extended immediate by instruction format; R-type and unknown give 0.
    function automatic logic [63:0] imm_of(input logic [31:0] ins);
        logic [63:0] v;
        case (ins[6:0])
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: v = {{52{ins[31]}}, ins[31:20]};
            OP_STORE:          v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:         v = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:  v = {{32{ins[31]}}, ins[31:12], 12'h000};
            OP_JAL:            v = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:           v = 64'd0;
        endcase
        return v;
    endfunction

    // Control word: {branch_or_jump, alu_src_imm, mem_write, mem_read, reg_write, funct7[5], funct3, opcode}.
    function automatic logic [15:0] ctrl_of(input logic [31:0] ins);
        logic rw, mr, mw, asi, bj;
        rw = 1'b0; mr = 1'b0; mw = 1'b0; asi = 1'b0; bj = 1'b0;
        case (ins[6:0])
            OP_LUI, OP_AUIPC:  begin rw = 1'b1; asi = 1'b1; end
            OP_JAL:            begin rw = 1'b1; bj = 1'b1; end
            OP_JALR:           begin rw = 1'b1; asi = 1'b1; bj = 1'b1; end
            OP_BRANCH:         begin bj = 1'b1; end
            OP_LOAD:           begin rw = 1'b1; mr = 1'b1; asi = 1'b1; end
            OP_STORE:          begin mw = 1'b1; asi = 1'b1; end
            OP_IMM, OP_IMM32:  begin rw = 1'b1; asi = 1'b1; end
            OP_REG, OP_REG32:  begin rw = 1'b1; end
            default:           begin rw = 1'b0; end
        endcase
        return {bj, asi, mw, mr, rw, ins[30], ins[14:12], ins[6:0]};
    endfunction

    // Static prediction; JALR target is unknown here so it falls through to pc+4.
    function automatic logic [63:0] predict(input logic [31:0] ins, input logic [63:0] fpc);
        logic [63:0] p;
        case (ins[6:0])
            OP_JAL:    p = fpc + imm_of(ins);
`ifdef IFETCH_BTFN_EN
            OP_BRANCH: p = ins[31] ? (fpc + imm_of(ins)) : (fpc + 64'd4);
`else
            OP_BRANCH: p = fpc + 64'd4;
`endif
            default:   p = fpc + 64'd4;
        endcase
        return p;
    endfunction

    state_t                    state_q, state_d;
    logic [57:0]               miss_line_q, miss_line_d;
    logic [2:0]                beat_q, beat_d;
    logic [31:0]               instr_q, instr_d;
    logic                      instr_valid_q, instr_valid_d;
    logic [63:0]               next_pc_q, next_pc_d;
    logic                      busy_q, busy_d;
    logic                      bus_reqcyc_q, bus_reqcyc_d;
    logic [63:0]               bus_req_q, bus_req_d;
    logic [NUM_LINES-1:0]      valid_q, valid_d;
    logic                      fill_we_s, fill_done_s;

    logic [BUS_DATA_WIDTH-1:0] data_mem [0:NUM_LINES*8-1];
    logic [TAG_W-1:0]          tag_mem  [0:NUM_LINES-1];

    logic [IDX_W-1:0]          fetch_idx_s, miss_idx_s;
    logic [TAG_W-1:0]          fetch_tag_s, miss_tag_s;
    logic                      hit_s;
    logic [63:0]               line_word_s;
    logic [31:0]               fetch_word_s;
    logic                      unused_s;

    assign fetch_idx_s  = pc[6+IDX_W-1:6];
    assign fetch_tag_s  = pc[63:6+IDX_W];
    assign miss_idx_s   = miss_line_q[IDX_W-1:0];
    assign miss_tag_s   = miss_line_q[57:IDX_W];
    assign hit_s        = valid_q[fetch_idx_s] && (tag_mem[fetch_idx_s] == fetch_tag_s);
    assign line_word_s  = data_mem[{fetch_idx_s, pc[5:3]}];
    assign fetch_word_s = pc[2] ? line_word_s[63:32] : line_word_s[31:0];
    assign unused_s     = ^{bus_resptag, pc[1:0]};

    // Next-state and fetch-result logic of the IDLE/REQ/FILL controller.
    always_comb begin
        state_d       = state_q;
        miss_line_d   = miss_line_q;
        beat_d        = beat_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        next_pc_d     = next_pc_q;
        bus_reqcyc_d  = bus_reqcyc_q;
        bus_req_d     = bus_req_q;
        valid_d       = valid_q;
        fill_we_s     = 1'b0;
        fill_done_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_req && hit_s) begin
                    instr_d       = fetch_word_s;
                    instr_valid_d = 1'b1;
                    next_pc_d     = predict(fetch_word_s, pc);
                end else if (fetch_req) begin
                    // Invalidate the victim now so a partly refilled line never hits.
                    state_d              = REQ;
                    miss_line_d          = pc[63:6];
                    beat_d               = 3'd0;
                    bus_reqcyc_d         = 1'b1;
                    bus_req_d            = {pc[63:6], 6'b000000};
                    valid_d[fetch_idx_s] = 1'b0;
                end else begin
                    instr_valid_d = 1'b0;
                end
            end
            REQ: begin
                if (bus_reqack) begin
                    state_d      = FILL;
                    bus_reqcyc_d = 1'b0;
                end else begin
                    bus_reqcyc_d = 1'b1;
                end
            end
            FILL: begin
                if (bus_respcyc) begin
                    fill_we_s = 1'b1;
                    beat_d    = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d             = IDLE;
                        valid_d[miss_idx_s] = 1'b1;
                        fill_done_s         = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Controller and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            miss_line_q   <= 58'd0;
            beat_q        <= 3'd0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            next_pc_q     <= 64'd0;
            busy_q        <= 1'b0;
            bus_reqcyc_q  <= 1'b0;
            bus_req_q     <= 64'd0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            miss_line_q   <= miss_line_d;
            beat_q        <= beat_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            next_pc_q     <= next_pc_d;
            busy_q        <= busy_d;
            bus_reqcyc_q  <= bus_reqcyc_d;
            bus_req_q     <= bus_req_d;
            valid_q       <= valid_d;
        end
    end

    // Cache data and tag storage; validity is tracked separately so no reset is needed.
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            data_mem[{miss_idx_s, beat_q}] <= bus_resp;
        end
        if (fill_done_s) begin
            tag_mem[miss_idx_s] <= miss_tag_s;
        end
    end

    assign busy        = busy_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign next_pc     = next_pc_q;
    assign rs1         = instr_q[19:15];
    assign rs2         = instr_q[24:20];
    assign rd          = instr_q[11:7];
    assign imm         = imm_of(instr_q);
    assign ctrl_bits   = ctrl_of(instr_q);
    assign bus_reqcyc  = bus_reqcyc_q;
    assign bus_req     = bus_req_q;
    assign bus_reqtag  = {1'b1, 4'b0001, 8'h00};
    // Beats are acknowledged in every state; outside FILL they are simply dropped.
    assign bus_respack = bus_respcyc;

endmodule

// File: tb/tb_ifetch_frontend.sv
module tb_ifetch_frontend;
    logic        clk = 1'b0;
    logic        reset, fetch_req, busy, instr_valid;
    logic [63:0] pc, next_pc, imm, bus_req, bus_resp;
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] ctrl_bits;
    logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [12:0] bus_reqtag, bus_resptag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] npc;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] imm;
        logic [15:0] ctrl;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    ifetch_frontend #(.NUM_LINES(64), .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .busy(busy),
        .instr_valid(instr_valid), .instr(instr), .next_pc(next_pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .ctrl_bits(ctrl_bits),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory image: hand-placed instructions, nops everywhere else.
    function automatic logic [63:0] mem_beat(input logic [63:0] a);
        case (a)
            64'h1000: return 64'h00500093_00000013;  // addi x1,x0,5 | nop
            64'h1008: return 64'h402081B3_FE20AC23;  // sub x3,x1,x2 | sw x2,-8(x1)
            64'h1010: return 64'h00000013_FFFFFFFF;  // nop | unknown opcode
            64'h2000: return 64'h00000013_0080006F;  // nop | jal x0,+8
            64'h3000: return 64'h00000013_FE000EE3;  // nop | beq x0,x0,-4
            default:  return 64'h00000013_00000013;
        endcase
    endfunction

    // Scoreboard monitor: every instr_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (instr_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_instr_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("instr",     {32'd0, instr},     {32'd0, mon_e.ins});
                check("next_pc",   next_pc,            mon_e.npc);
                check("regs",      {49'd0, rs1, rs2, rd}, {49'd0, mon_e.rs1, mon_e.rs2, mon_e.rd});
                check("imm",       imm,                mon_e.imm);
                check("ctrl_bits", {48'd0, ctrl_bits}, {48'd0, mon_e.ctrl});
            end
        end
    end

    task automatic fetch_hit(input logic [63:0] p, input logic [31:0] ins, input logic [63:0] npc,
                             input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic [4:0] e_rd,
                             input logic [63:0] e_imm, input logic [15:0] e_ctrl);
        exp_t e;
        e.ins = ins; e.npc = npc; e.rs1 = e_rs1; e.rs2 = e_rs2; e.rd = e_rd;
        e.imm = e_imm; e.ctrl = e_ctrl;
        fetch_req = 1'b1;
        pc = p;
        sb.push_back(e);
        @(negedge clk);
        fetch_req = 1'b0;
        check("hit_not_busy", {63'd0, busy}, 64'd0);
        check("hit_no_bus", {63'd0, bus_reqcyc}, 64'd0);
    endtask

    // Miss with full refill; abort_beat in 0..7 asserts reset while that beat is on the bus.
    task automatic miss_fill(input logic [63:0] p, input int abort_beat);
        logic [63:0] line;
        line = {p[63:6], 6'b000000};
        fetch_req = 1'b1;
        pc = p;
        @(negedge clk);
        check("miss_busy", {63'd0, busy}, 64'd1);
        check("miss_reqcyc", {63'd0, bus_reqcyc}, 64'd1);
        check("miss_req_addr", bus_req, line);
        check("miss_reqtag", {51'd0, bus_reqtag}, 64'h1100);
        pc = 64'h5000;  // must be ignored while the miss is outstanding
        @(negedge clk);
        check("req_held", {63'd0, bus_reqcyc}, 64'd1);
        check("req_addr_held", bus_req, line);
        fetch_req = 1'b0;
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        check("ack_drops_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
        for (int b = 0; b < 8; b++) begin
            bus_respcyc = 1'b1;
            bus_resp = mem_beat(line + 64'(8 * b));
            if (b == abort_beat) reset = 1'b1;
            #1;
            check("fill_busy", {63'd0, busy}, 64'd1);
            check("respack", {63'd0, bus_respack}, 64'd1);
            @(negedge clk);
            if (b == abort_beat) begin
                reset = 1'b0;
                bus_respcyc = 1'b0;
                check("abort_busy", {63'd0, busy}, 64'd0);
                check("abort_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
                check("abort_next_pc", next_pc, 64'd0);
                return;
            end
        end
        bus_respcyc = 1'b0;
        check("fill_done_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] beq_npc;
`ifdef IFETCH_BTFN_EN
        beq_npc = 64'h2FFC;
`else
        beq_npc = 64'h3004;
`endif
        reset = 1'b1; fetch_req = 1'b0; pc = 64'd0; bus_reqack = 1'b0;
        bus_respcyc = 1'b0; bus_resp = 64'd0; bus_resptag = 13'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_instr", {32'd0, instr}, 64'd0);
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_next_pc", next_pc, 64'd0);
        check("rst_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
        check("rst_req", bus_req, 64'd0);
        check("rst_decode", {imm[47:0], ctrl_bits}, 64'd0);
        check("rst_regs", {49'd0, rs1, rs2, rd}, 64'd0);

        // Cold miss, then hits across the line.
        miss_fill(64'h1000, -1);
        fetch_hit(64'h1000, 32'h00000013, 64'h1004, 5'd0, 5'd0, 5'd0, 64'd0, 16'h4813);
        fetch_hit(64'h1004, 32'h00500093, 64'h1008, 5'd0, 5'd5, 5'd1, 64'd5, 16'h4813);
        fetch_hit(64'h1008, 32'hFE20AC23, 64'h100C, 5'd1, 5'd2, 5'd24, 64'hFFFF_FFFF_FFFF_FFF8, 16'h6523);
        fetch_hit(64'h100C, 32'h402081B3, 64'h1010, 5'd1, 5'd2, 5'd3, 64'd0, 16'h0C33);
        fetch_hit(64'h1010, 32'hFFFFFFFF, 64'h1014, 5'd31, 5'd31, 5'd31, 64'd0, 16'h07FF);

        // Stray beat in IDLE: acknowledged and dropped, cached data untouched.
        bus_respcyc = 1'b1;
        bus_resp = 64'hDEADBEEF_DEADBEEF;
        #1;
        check("stray_respack", {63'd0, bus_respack}, 64'd1);
        @(negedge clk);
        bus_respcyc = 1'b0;
        fetch_hit(64'h1004, 32'h00500093, 64'h1008, 5'd0, 5'd5, 5'd1, 64'd5, 16'h4813);

        // 0x2000 maps onto the same line as 0x1000.
        miss_fill(64'h2000, -1);
        fetch_hit(64'h2000, 32'h0080006F, 64'h2008, 5'd0, 5'd8, 5'd0, 64'd8, 16'h886F);
        miss_fill(64'h1000, -1);
        fetch_hit(64'h1000, 32'h00000013, 64'h1004, 5'd0, 5'd0, 5'd0, 64'd0, 16'h4813);

        miss_fill(64'h3000, -1);
        fetch_hit(64'h3000, 32'hFE000EE3, beq_npc, 5'd0, 5'd0, 5'd29, 64'hFFFF_FFFF_FFFF_FFFC, 16'h8463);

        // Reset during beat 3 leaves the line invalid.
        miss_fill(64'h4004, 3);
        miss_fill(64'h4004, -1);
        fetch_hit(64'h4004, 32'h00000013, 64'h4008, 5'd0, 5'd0, 5'd0, 64'd0, 16'h4813);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
